l1_cache_responder: RTL and testbench

- Wishbone slave that terminates the CPU's cache port (`cpu_to_cache`).
- Direct-mapped, write-back, write-allocate cache of 128-bit lines.
- Serves hits from local arrays. On a miss, issues line-wide writeback/fill transactions as a Wishbone master to physical memory (`cache_to_mem`).
- Sits between the CPU and physical memory.

---
 rtl/lc3b_types.sv | 24 ++
 rtl/wishbone.sv | 24 ++
 rtl/l1_cache_array.sv | 56 +++++
 rtl/l1_cache_responder.sv | 172 +++++++++++++++++
 tb/tb_l1_cache_responder.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory hierarchy.
// Cache geometry, line/select types and the cache controller states.
package lc3b_types;

    localparam int C_NUM_LINES = 8;
    localparam int C_IDX_W = $clog2(C_NUM_LINES);
    localparam int C_TAG_W = 12 - C_IDX_W;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0] lc3b_line_sel;
    typedef logic [C_TAG_W-1:0] lc3b_c_tag;
    typedef logic [C_IDX_W-1:0] lc3b_c_index;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESPOND
    } lc3b_cache_state;

    localparam lc3b_line_sel SEL_ALL = 16'hFFFF;

endpackage

// File: rtl/wishbone.sv
// Line-wide Wishbone bus between CPU, cache and memory.
// Master drives the request fields; slave returns data and ACK.
interface wishbone;

    logic CYC;
    logic STB;
    logic WE;
    logic [15:0] SEL;
    logic [15:0] ADR;
    logic [127:0] DAT_M;
    logic [127:0] DAT_S;
    logic ACK;

    modport master (
        output CYC, STB, WE, SEL, ADR, DAT_M,
        input DAT_S, ACK
    );

    modport slave (
        input CYC, STB, WE, SEL, ADR, DAT_M,
        output DAT_S, ACK
    );

endinterface

// File: rtl/l1_cache_array.sv
// Direct-mapped storage: valid, dirty, tag and data per line.
// Combinational read by index; byte-enabled synchronous write.
module l1_cache_array
    import lc3b_types::*;
#(
    parameter int NUM_LINES = C_NUM_LINES,
    localparam int IDX_W = $clog2(NUM_LINES),
    localparam int TAG_W = 12 - IDX_W
) (
    input logic clk,
    input logic rst_n,
    input logic [IDX_W-1:0] idx,
    input lc3b_line_sel wr_be,
    input lc3b_line wr_data,
    input logic tag_we,
    input logic [TAG_W-1:0] tag_in,
    input logic set_valid,
    input logic set_dirty,
    input logic clr_dirty,
    output logic valid,
    output logic dirty,
    output logic [TAG_W-1:0] tag_out,
    output lc3b_line line_out
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q [NUM_LINES];
    lc3b_line data_q [NUM_LINES];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag_out = tag_q[idx];
    assign line_out = data_q[idx];

    // Line state bits are the only reset storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (set_valid) valid_q[idx] <= 1'b1;
            if (set_dirty) dirty_q[idx] <= 1'b1;
            else if (clr_dirty) dirty_q[idx] <= 1'b0;
        end
    end

    // Data and tag are meaningless until valid, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (wr_be[i]) data_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
        if (tag_we) tag_q[idx] <= tag_in;
    end

endmodule

// File: rtl/l1_cache_responder.sv
// Write-back, write-allocate L1 cache between CPU and memory.
// Hits served locally; misses do line writeback then fill.
module l1_cache_responder
    import lc3b_types::*;
#(
    parameter int NUM_LINES = C_NUM_LINES
) (
    input logic clk,
    input logic rst_n,
    wishbone.slave cpu_to_cache,
    wishbone.master cache_to_mem
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 12 - IDX_W;

    lc3b_cache_state state, state_nxt;

    logic [15:4] adr_q;
    logic we_q;
    lc3b_line_sel sel_q;
    lc3b_line wdat_q;
    logic abort_q;
    logic ack_q;
    lc3b_line dat_s_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic line_valid;
    logic line_dirty;
    logic [TAG_W-1:0] line_tag;
    lc3b_line line_data;

    lc3b_line_sel wr_be;
    lc3b_line wr_data;
    logic tag_we;
    logic set_valid;
    logic set_dirty;
    logic clr_dirty;

    logic req;
    logic hit;
    logic ack_d;

    assign req = cpu_to_cache.CYC & cpu_to_cache.STB;
    assign idx = adr_q[4+IDX_W-1:4];
    assign tag = adr_q[15:4+IDX_W];
    assign hit = line_valid && (line_tag == tag);
    assign ack_d = (state == LOOKUP) && hit && !abort_q && cpu_to_cache.CYC;

    assign cpu_to_cache.ACK = ack_q;
    assign cpu_to_cache.DAT_S = dat_s_q;

    l1_cache_array #(
        .NUM_LINES(NUM_LINES)
    ) u_array (
        .clk(clk),
        .rst_n(rst_n),
        .idx(idx),
        .wr_be(wr_be),
        .wr_data(wr_data),
        .tag_we(tag_we),
        .tag_in(tag),
        .set_valid(set_valid),
        .set_dirty(set_dirty),
        .clr_dirty(clr_dirty),
        .valid(line_valid),
        .dirty(line_dirty),
        .tag_out(line_tag),
        .line_out(line_data)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    // Latch the request in IDLE; remember if the CPU walked away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q <= '0;
            we_q <= 1'b0;
            sel_q <= '0;
            wdat_q <= '0;
            abort_q <= 1'b0;
        end else if (state == IDLE && req) begin
            adr_q <= cpu_to_cache.ADR[15:4];
            we_q <= cpu_to_cache.WE;
            sel_q <= cpu_to_cache.SEL;
            wdat_q <= cpu_to_cache.DAT_M;
            abort_q <= 1'b0;
        end else if (state != IDLE && !cpu_to_cache.CYC) begin
            abort_q <= 1'b1;
        end
    end

    // Registered CPU response, loaded on the LOOKUP hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            dat_s_q <= '0;
        end else begin
            ack_q <= ack_d;
            if (state == LOOKUP && hit) dat_s_q <= line_data;
        end
    end

    // Next state, memory bus and array update controls.
    // A completed fill re-enters LOOKUP, which then hits.
    always_comb begin
        state_nxt = state;
        wr_be = '0;
        wr_data = '0;
        tag_we = 1'b0;
        set_valid = 1'b0;
        set_dirty = 1'b0;
        clr_dirty = 1'b0;
        cache_to_mem.CYC = 1'b0;
        cache_to_mem.STB = 1'b0;
        cache_to_mem.WE = 1'b0;
        cache_to_mem.SEL = '0;
        cache_to_mem.ADR = '0;
        cache_to_mem.DAT_M = '0;
        unique case (state)
            IDLE: begin
                if (req) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) state_nxt = RESPOND;
                else if (line_valid && line_dirty) state_nxt = WRITEBACK;
                else state_nxt = FILL;
            end
            WRITEBACK: begin
                cache_to_mem.CYC = 1'b1;
                cache_to_mem.STB = 1'b1;
                cache_to_mem.WE = 1'b1;
                cache_to_mem.SEL = SEL_ALL;
                cache_to_mem.ADR = {line_tag, idx, 4'h0};
                cache_to_mem.DAT_M = line_data;
                if (cache_to_mem.ACK) begin
                    clr_dirty = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                cache_to_mem.CYC = 1'b1;
                cache_to_mem.STB = 1'b1;
                cache_to_mem.SEL = SEL_ALL;
                cache_to_mem.ADR = {tag, idx, 4'h0};
                if (cache_to_mem.ACK) begin
                    wr_be = SEL_ALL;
                    wr_data = cache_to_mem.DAT_S;
                    tag_we = 1'b1;
                    set_valid = 1'b1;
                    clr_dirty = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            RESPOND: begin
                if (ack_q && we_q) begin
                    wr_be = sel_q;
                    wr_data = wdat_q;
                    set_dirty = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l1_cache_responder.sv
// Testbench for l1_cache_responder.
// Scoreboard of expected read data plus a latency-3 memory model.
module tb_l1_cache_responder;

    logic clk;
    logic rst_n;

    wishbone cpu ();
    wishbone mem ();

    l1_cache_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_to_cache(cpu),
        .cache_to_mem(mem)
    );

    typedef struct {
        logic chk;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        logic we;
        logic [15:0] adr;
        logic [15:0] sel;
        logic [127:0] dat;
    } txn_t;

    exp_t exp_q[$];
    txn_t mlog[$];
    logic [127:0] gold [logic [15:0]];
    logic [127:0] phys [logic [15:0]];

    int n_cmp;
    int n_err;
    int cyc;
    int mem_ack_cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [127:0] init_line(input logic [15:0] a);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) begin
            l[16*i +: 16] = (a ^ 16'hA5C3) + 16'(i * 257);
        end
        return l;
    endfunction

    function automatic logic [127:0] phys_line(input logic [15:0] a);
        logic [15:0] la;
        la = {a[15:4], 4'h0};
        if (phys.exists(la)) return phys[la];
        return init_line(la);
    endfunction

    function automatic logic [127:0] gold_line(input logic [15:0] a);
        logic [15:0] la;
        la = {a[15:4], 4'h0};
        if (gold.exists(la)) return gold[la];
        return init_line(la);
    endfunction

    // Memory: ACK on the third cycle of a request, one cycle wide.
    initial begin
        int cnt;
        txn_t t;
        cnt = 0;
        mem.ACK = 1'b0;
        mem.DAT_S = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1 || mem.ACK) begin
                mem.ACK = 1'b0;
                cnt = 0;
            end else if (mem.CYC && mem.STB) begin
                cnt++;
                if (cnt == 3) begin
                    t.we = mem.WE;
                    t.adr = mem.ADR;
                    t.sel = mem.SEL;
                    t.dat = mem.DAT_M;
                    mlog.push_back(t);
                    if (mem.WE) phys[mem.ADR] = mem.DAT_M;
                    else mem.DAT_S = phys_line(mem.ADR);
                    mem.ACK = 1'b1;
                    mem_ack_cyc = cyc;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard: every CPU ACK pops one expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu.ACK === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: ACK=1 with no request outstanding");
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk && cpu.DAT_S !== e.data) begin
                        n_err++;
                        $display("FAIL read_data: got %h expected %h", cpu.DAT_S, e.data);
                    end
                end
                n_cmp++;
                if (prev) begin
                    n_err++;
                    $display("FAIL ack_consecutive: ACK=1 two cycles running, required 0");
                end
            end
            prev = (cpu.ACK === 1'b1);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Issue one CPU request from a negedge; returns at the ACK negedge.
    task automatic cpu_req(
        input logic we,
        input logic [15:0] adr,
        input logic [15:0] sel,
        input logic [127:0] wd,
        input logic hold,
        output int lat,
        output int mcyc,
        output int ack_at
    );
        exp_t e;
        logic [127:0] l;
        l = gold_line(adr);
        cpu.CYC = 1'b1;
        cpu.STB = 1'b1;
        cpu.WE = we;
        cpu.ADR = adr;
        cpu.SEL = sel;
        cpu.DAT_M = wd;
        if (we) begin
            for (int i = 0; i < 16; i++) begin
                if (sel[i]) l[8*i +: 8] = wd[8*i +: 8];
            end
            gold[{adr[15:4], 4'h0}] = l;
        end
        e.chk = !we;
        e.data = l;
        exp_q.push_back(e);
        lat = 0;
        mcyc = 0;
        ack_at = 0;
        while (lat < 80) begin
            @(negedge clk);
            lat++;
            if (mem.CYC === 1'b1) mcyc++;
            if (cpu.ACK === 1'b1) break;
        end
        if (cpu.ACK !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout: adr %h no ACK within %0d cycles", adr, lat);
            void'(exp_q.pop_back());
        end
        ack_at = cyc;
        if (!hold) begin
            cpu.CYC = 1'b0;
            cpu.STB = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu.CYC = 1'b0;
        cpu.STB = 1'b0;
        cpu.WE = 1'b0;
        cpu.SEL = '0;
        cpu.ADR = '0;
        cpu.DAT_M = '0;
        idle(2);
        n_cmp++;
        if (cpu.ACK !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ack: got %b expected 0", cpu.ACK);
        end
        n_cmp++;
        if (cpu.DAT_S !== 128'h0) begin
            n_err++;
            $display("FAIL rst_dat_s: got %h expected 0", cpu.DAT_S);
        end
        n_cmp++;
        if ({mem.CYC, mem.STB, mem.WE} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mem_ctl: got %b expected 000", {mem.CYC, mem.STB, mem.WE});
        end
        n_cmp++;
        if (mem.SEL !== 16'h0 || mem.ADR !== 16'h0 || mem.DAT_M !== 128'h0) begin
            n_err++;
            $display("FAIL rst_mem_bus: sel %h adr %h dat %h expected all 0", mem.SEL, mem.ADR, mem.DAT_M);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_cold_miss();
        int lat, mc, at;
        mlog.delete();
        cpu_req(1'b0, 16'h1234, 16'hFFFF, '0, 1'b0, lat, mc, at);
        n_cmp++;
        if (mlog.size() != 1) begin
            n_err++;
            $display("FAIL cold_txn_count: got %0d expected 1", mlog.size());
        end else begin
            n_cmp++;
            if (mlog[0].we !== 1'b0 || mlog[0].adr !== 16'h1230 || mlog[0].sel !== 16'hFFFF) begin
                n_err++;
                $display("FAIL cold_fill_req: we %b adr %h sel %h expected 0 1230 ffff", mlog[0].we, mlog[0].adr, mlog[0].sel);
            end
        end
        n_cmp++;
        if (at - mem_ack_cyc != 2) begin
            n_err++;
            $display("FAIL cold_latency: got %0d cycles after mem ACK expected 2", at - mem_ack_cyc);
        end
        idle(1);
        mlog.delete();
        cpu_req(1'b0, 16'h1234, 16'hFFFF, '0, 1'b0, lat, mc, at);
        n_cmp++;
        if (lat != 2 || mc != 0 || mlog.size() != 0) begin
            n_err++;
            $display("FAIL read_hit: lat %0d mem cycles %0d txns %0d expected 2 0 0", lat, mc, mlog.size());
        end
        idle(1);
    endtask

    task automatic test_write_hit();
        int lat, mc, at;
        logic [127:0] wd;
        wd = {$urandom, $urandom, $urandom, $urandom};
        wd[47:32] = 16'hBEEF;
        cpu_req(1'b1, 16'h1234, 16'h0030, wd, 1'b0, lat, mc, at);
        n_cmp++;
        if (lat != 2 || mc != 0) begin
            n_err++;
            $display("FAIL write_hit: lat %0d mem cycles %0d expected 2 0", lat, mc);
        end
        idle(1);
        cpu_req(1'b0, 16'h1238, 16'hFFFF, '0, 1'b0, lat, mc, at);
        n_cmp++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL merged_read_lat: got %0d expected 2", lat);
        end
        idle(1);
    endtask

    task automatic test_dirty_evict();
        int lat, mc, at;
        mlog.delete();
        cpu_req(1'b0, 16'h12B4, 16'hFFFF, '0, 1'b0, lat, mc, at);
        n_cmp++;
        if (mlog.size() != 2) begin
            n_err++;
            $display("FAIL evict_txn_count: got %0d expected 2", mlog.size());
        end else begin
            n_cmp++;
            if (mlog[0].we !== 1'b1 || mlog[0].adr !== 16'h1230 || mlog[0].sel !== 16'hFFFF) begin
                n_err++;
                $display("FAIL evict_wb_req: we %b adr %h sel %h expected 1 1230 ffff", mlog[0].we, mlog[0].adr, mlog[0].sel);
            end
            n_cmp++;
            if (mlog[0].dat !== gold_line(16'h1230)) begin
                n_err++;
                $display("FAIL evict_wb_data: got %h expected %h", mlog[0].dat, gold_line(16'h1230));
            end
            n_cmp++;
            if (mlog[1].we !== 1'b0 || mlog[1].adr !== 16'h12B0) begin
                n_err++;
                $display("FAIL evict_fill_req: we %b adr %h expected 0 12b0", mlog[1].we, mlog[1].adr);
            end
        end
        idle(1);
        mlog.delete();
        cpu_req(1'b0, 16'h1234, 16'hFFFF, '0, 1'b0, lat, mc, at);
        n_cmp++;
        if (mlog.size() != 1 || mlog[0].we !== 1'b0 || mlog[0].adr !== 16'h1230) begin
            n_err++;
            $display("FAIL clean_victim: txns %0d expected a single fill of 1230", mlog.size());
        end
        idle(1);
    endtask

    task automatic test_sel0_write();
        int lat, mc, at;
        mlog.delete();
        cpu_req(1'b1, 16'h1234, 16'h0000, {$urandom, $urandom, $urandom, $urandom}, 1'b0, lat, mc, at);
        n_cmp++;
        if (lat != 2 || mc != 0) begin
            n_err++;
            $display("FAIL sel0_ack: lat %0d mem cycles %0d expected 2 0", lat, mc);
        end
        idle(1);
        cpu_req(1'b0, 16'h12B4, 16'hFFFF, '0, 1'b0, lat, mc, at);
        n_cmp++;
        if (mlog.size() != 2) begin
            n_err++;
            $display("FAIL sel0_dirty: txns %0d expected 2 (writeback then fill)", mlog.size());
        end else begin
            n_cmp++;
            if (mlog[0].we !== 1'b1 || mlog[0].dat !== gold_line(16'h1230)) begin
                n_err++;
                $display("FAIL sel0_data: wb we %b dat %h expected 1 %h", mlog[0].we, mlog[0].dat, gold_line(16'h1230));
            end
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, mc1, mc2, at;
        cpu_req(1'b0, 16'h2054, 16'hFFFF, '0, 1'b0, lat1, mc1, at);
        idle(1);
        mlog.delete();
        cpu_req(1'b0, 16'h2058, 16'hFFFF, '0, 1'b1, lat1, mc1, at);
        cpu_req(1'b0, 16'h12BC, 16'hFFFF, '0, 1'b0, lat2, mc2, at);
        n_cmp++;
        if (lat1 != 2 || lat2 != 3) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d/%0d expected 2/3", lat1, lat2);
        end
        n_cmp++;
        if (mlog.size() != 0 || mc1 + mc2 != 0) begin
            n_err++;
            $display("FAIL b2b_mem: txns %0d expected 0", mlog.size());
        end
        idle(1);
    endtask

    task automatic test_abort();
        int lat, mc, at, acks;
        logic seen;
        mlog.delete();
        cpu.CYC = 1'b1;
        cpu.STB = 1'b1;
        cpu.WE = 1'b0;
        cpu.ADR = 16'h4060;
        cpu.SEL = 16'hFFFF;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (mem.CYC === 1'b1);
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL abort_fill_start: mem CYC=0 expected fill to begin");
        end
        cpu.CYC = 1'b0;
        cpu.STB = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu.ACK === 1'b1) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL abort_ack: got %0d ACKs expected 0", acks);
        end
        n_cmp++;
        if (mlog.size() != 1 || mlog[0].adr !== 16'h4060) begin
            n_err++;
            $display("FAIL abort_fill: txns %0d expected one fill of 4060", mlog.size());
        end
        mlog.delete();
        cpu_req(1'b0, 16'h4064, 16'hFFFF, '0, 1'b0, lat, mc, at);
        n_cmp++;
        if (lat != 2 || mc != 0) begin
            n_err++;
            $display("FAIL abort_installed: lat %0d mem cycles %0d expected 2 0", lat, mc);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_wb();
        int lat, mc, at;
        logic seen;
        cpu_req(1'b1, 16'h4064, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom}, 1'b0, lat, mc, at);
        idle(1);
        mlog.delete();
        cpu.CYC = 1'b1;
        cpu.STB = 1'b1;
        cpu.WE = 1'b0;
        cpu.ADR = 16'h4164;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (mem.CYC === 1'b1 && mem.WE === 1'b1);
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL rwb_start: no writeback seen for dirty victim");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem.CYC, mem.STB, mem.WE} !== 3'b000) begin
            n_err++;
            $display("FAIL rwb_mem_ctl: got %b expected 000", {mem.CYC, mem.STB, mem.WE});
        end
        n_cmp++;
        if (mem.SEL !== 16'h0 || mem.ADR !== 16'h0 || mem.DAT_M !== 128'h0) begin
            n_err++;
            $display("FAIL rwb_mem_bus: sel %h adr %h dat %h expected all 0", mem.SEL, mem.ADR, mem.DAT_M);
        end
        n_cmp++;
        if (cpu.ACK !== 1'b0 || cpu.DAT_S !== 128'h0) begin
            n_err++;
            $display("FAIL rwb_cpu: ack %b dat %h expected 0 0", cpu.ACK, cpu.DAT_S);
        end
        cpu.CYC = 1'b0;
        cpu.STB = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        mlog.delete();
        cpu_req(1'b0, 16'h12B4, 16'hFFFF, '0, 1'b0, lat, mc, at);
        n_cmp++;
        if (mlog.size() != 1 || mlog[0].we !== 1'b0 || mlog[0].adr !== 16'h12B0) begin
            n_err++;
            $display("FAIL rwb_invalidated: txns %0d expected one fill of 12b0", mlog.size());
        end
        idle(1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mem_ack_cyc = 0;
        test_reset();
        test_cold_miss();
        test_write_hit();
        test_dirty_evict();
        test_sel0_write();
        test_back_to_back();
        test_abort();
        test_reset_mid_wb();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
